pin_entry_display: RTL and testbench
====================================

# pin_entry_display

Keypad-to-display staging block for the door lock. It accepts decoded keypad codes, accumulates up to six PIN digits, applies masking (newest digit briefly visible, older digits shown as dashes), and drives a `bcdPac_t` packet plus enable straight into the six-digit 7-segment controller. It also hands a completed PIN to the lock comparator on submit and clears itself after an idle timeout.

## Interface
- `MASK_CYCLES`, default 50_000_000: cycles the newest digit stays visible before it is masked; must be ≥1.
- `IDLE_CYCLES`, default 500_000_000: cycles without an accepted key before the buffer auto-clears; must be greater than `MASK_CYCLES`.
- `clk` in 1: system clock. All logic is on the rising edge of this single clock.
- `rst` in 1: asynchronous, active-low reset.
- `key_valid` in 1: one-cycle strobe qualifying `key_code`.
- `key_code` in 4: 0x0–0x9 are digits, 0xB is backspace, 0xC is clear, 0xE is submit. All other codes are ignored.
- `reveal` in 1: level input; when high, all stored digits are shown unmasked.
- `bcd_packet` out `bcdPac_t`: display codes; `BCD0` is the rightmost position.
- `disp_enable` out 1: display update enable.
- `digit_count` out 3: number of stored digits, 0–6.
- `pin_valid` out 1: one-cycle strobe marking a submitted PIN.
- `pin_digits` out 24: submitted PIN, first-entered digit in [23:20] and last-entered digit in [3:0].

## Operation
- **Storage:** a six-entry digit shift register plus `digit_count`.
  - A digit key shifts the stored digits up one position (BCD0→BCD1…) and loads the new digit into BCD0.
  - Positions ≥ `digit_count` display 0xF (blank).
- **Masking:**
  - The stored digit in BCD0 displays its value while the mask timer runs.
  - All other occupied positions display 0xA (dash).
  - When `reveal`=1, every occupied position displays its value.
- **Keys:**
  - Digit key with `digit_count`<6: stored and counted; the mask timer reloads.
  - Digit key with `digit_count`=6: ignored, no state change, and the idle timer is not restarted.
  - Backspace: shifts down (BCD1→BCD0…), decrements the count, and stops the mask timer, so the new BCD0 is masked. It is a no-op when empty.
  - Clear: sets the count to 0 and all positions blank.
  - Submit with count=6: `pin_valid`=1 for one cycle with `pin_digits`, and the buffer clears in the same update.
  - Submit with count<6: ignored.
  - Ignored codes have no effect on any state or timer.
- **FSM states:**
  - IDLE: count=0.
  - ENTRY: 0<count<6.
  - FULL: count=6.
- **FSM transitions:**
  - IDLE→ENTRY on a digit.
  - ENTRY→FULL on the sixth digit.
  - FULL→ENTRY on backspace.
  - Any state→IDLE on clear, on an accepted submit, on idle timeout, or when backspace empties the buffer.
- **Idle timer:**
  - Restarts on every accepted key.
  - On expiry in ENTRY or FULL, the buffer clears.
  - Does not run in IDLE.
- `disp_enable` is 0 in reset and 1 from the first clock edge after reset release onward. The consumer freezes its outputs when enable is low, so enable is never dropped in normal operation.

## Timing
- All outputs are registered.
- **Reset values:**
  - `bcd_packet` all 0xF.
  - `disp_enable`=0.
  - `digit_count`=0.
  - `pin_valid`=0.
  - `pin_digits`=0.
  - FSM in IDLE, both timers stopped.
- **Key latency:** a key sampled at edge N is reflected on `bcd_packet`, `digit_count` and `pin_valid` after edge N.
- **Mask timing:** the newest digit is visible for exactly `MASK_CYCLES` cycles after its update cycle, then shows 0xA.
- **Reveal latency:** `reveal` changes take effect one cycle after sampling.
- **Idle timing:** the buffer clears exactly `IDLE_CYCLES` cycles after the last accepted key.
  - If a key is accepted on the expiry cycle, the key wins and the timer restarts.
- **Reset assertion:** takes effect immediately, without a clock edge, from any state. It aborts a pending `pin_valid`.
- Back-to-back `key_valid` strobes on consecutive cycles are each processed.

## Structure
- **Shared package `doorlock_pkg`:**
  - `bcdPac_t`.
  - Key constants `KEY_BACKSPACE`=0xB, `KEY_CLEAR`=0xC, `KEY_SUBMIT`=0xE.
  - Display codes `DISP_DASH`=0xA, `DISP_BLANK`=0xF.
  - The FSM state enum.
- **Sub-module `cycle_timer`:**
  - Parameterized down-counter with load/stop inputs and a one-cycle expiry strobe.
  - Instantiated twice, once as the mask timer and once as the idle timer.

## Test plan
Benches use `MASK_CYCLES`=4 and `IDLE_CYCLES`=20.
1. Hold `rst` low, no clock edges → packet all 0xF, `disp_enable`=0, `digit_count`=0, `pin_valid`=0. Release → `disp_enable`=1 after the first edge.
2. Keys 1,2,3 →
   - After the key-3 update: BCD0=3, BCD1=A, BCD2=A, BCD3–5=F.
   - 4 cycles later: BCD0=A.
   - `reveal`=1: BCD2..0 show 1,2,3.
3. Keys 1..7, then submit →
   - `digit_count` stays 6 and the 7th key is ignored.
   - One-cycle `pin_valid` with `pin_digits`=0x123456.
   - Next cycle: packet all 0xF, count 0.
4. Backspace when empty → no change. Keys 5,9 then backspace → count 1, BCD0=A immediately.
5. Key 4, then idle →
   - With no further key: cleared exactly 20 cycles later.
   - Repeat with key 8 on cycle 20: count 2 and the timer restarts.
6. Assert `rst` between key strobes mid-entry (count 3) → all outputs reach reset values asynchronously, with no `pin_valid` glitch.

Source files
------------

// File: rtl/doorlock_pkg.sv
// doorlock_pkg: display packet type, keypad/display codes and PIN entry states
package doorlock_pkg;
  typedef struct packed {
    logic [3:0] BCD5;
    logic [3:0] BCD4;
    logic [3:0] BCD3;
    logic [3:0] BCD2;
    logic [3:0] BCD1;
    logic [3:0] BCD0;
  } bcdPac_t;
  localparam logic [3:0] KEY_BACKSPACE = 4'hB;
  localparam logic [3:0] KEY_CLEAR     = 4'hC;
  localparam logic [3:0] KEY_SUBMIT    = 4'hE;
  localparam logic [3:0] DISP_DASH     = 4'hA;
  localparam logic [3:0] DISP_BLANK    = 4'hF;
  typedef enum logic [1:0] {ST_IDLE, ST_ENTRY, ST_FULL} pin_state_e;
endpackage

// File: rtl/pin_entry_display_if.sv
// pin_entry_display_if: keypad input and display/comparator output bundle
interface pin_entry_display_if;
  logic                      key_valid;
  logic [3:0]                key_code;
  logic                      reveal;
  doorlock_pkg::bcdPac_t     bcd_packet;
  logic                      disp_enable;
  logic [2:0]                digit_count;
  logic                      pin_valid;
  logic [23:0]               pin_digits;
  modport master (
    output key_valid, key_code, reveal,
    input  bcd_packet, disp_enable, digit_count, pin_valid, pin_digits
  );
  modport slave (
    input  key_valid, key_code, reveal,
    output bcd_packet, disp_enable, digit_count, pin_valid, pin_digits
  );
endinterface

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter, expire_o pulses in the last counted cycle
module cycle_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic stop_i,
  output logic expire_o
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load_i ? W'(CYCLES) : stop_i ? '0 : (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  end
  // Expiry depends only on the register so callers may feed it back into load/stop.
  assign expire_o = (cnt_q == W'(1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pin_entry_display.sv
// pin_entry_display: keypad PIN accumulator with masked 7-segment packet output
module pin_entry_display
  import doorlock_pkg::*;
#(
  parameter int unsigned MASK_CYCLES = 50_000_000,
  parameter int unsigned IDLE_CYCLES = 500_000_000
) (
  input logic                clk,
  input logic                rst,
  pin_entry_display_if.slave bus
);
  pin_state_e  state_q, state_d;
  logic [2:0]  count_q, count_d;
  logic [23:0] digits_q, digits_d, pin_digits_q, pin_digits_d, pkt_d;
  bcdPac_t     bcd_packet_q;
  logic        vis_q, vis_d, disp_enable_q, pin_valid_q;
  logic        dig_ok, bsp_ok, clr_ok, sub_ok, accept, flush;
  logic        mask_exp, idle_exp, mask_load, mask_stop, idle_load, idle_stop;
  always_comb begin
    dig_ok       = bus.key_valid && bus.key_code <= 4'd9 && state_q != ST_FULL;
    bsp_ok       = bus.key_valid && bus.key_code == KEY_BACKSPACE && state_q != ST_IDLE;
    clr_ok       = bus.key_valid && bus.key_code == KEY_CLEAR;
    sub_ok       = bus.key_valid && bus.key_code == KEY_SUBMIT && state_q == ST_FULL;
    accept       = dig_ok || bsp_ok || clr_ok || sub_ok;
    flush        = clr_ok || sub_ok || (idle_exp && !accept);
    count_d      = dig_ok ? count_q + 3'd1 : bsp_ok ? count_q - 3'd1 : flush ? 3'd0 : count_q;
    digits_d     = dig_ok ? {digits_q[19:0], bus.key_code} :
                   bsp_ok ? {4'h0, digits_q[23:4]} : flush ? 24'h0 : digits_q;
    vis_d        = dig_ok ? 1'b1 : (accept || flush || mask_exp) ? 1'b0 : vis_q;
    state_d      = (count_d == 3'd0) ? ST_IDLE : (count_d == 3'd6) ? ST_FULL : ST_ENTRY;
    pin_digits_d = sub_ok ? digits_q : pin_digits_q;
    mask_load    = dig_ok;
    mask_stop    = !dig_ok && (accept || flush);
    idle_load    = accept && state_d != ST_IDLE;
    idle_stop    = state_d == ST_IDLE;
    pkt_d        = '0;
    // The packet is built from next-state values so it lands in the same update as the key.
    for (int i = 0; i < 6; i++)
      pkt_d[4*i +: 4] = (3'(i) >= count_d) ? DISP_BLANK :
                        (bus.reveal || (i == 0 && vis_d)) ? digits_d[4*i +: 4] : DISP_DASH;
  end
  cycle_timer #(.CYCLES(MASK_CYCLES)) u_mask (
    .clk(clk), .rst(rst), .load_i(mask_load), .stop_i(mask_stop), .expire_o(mask_exp)
  );
  cycle_timer #(.CYCLES(IDLE_CYCLES)) u_idle (
    .clk(clk), .rst(rst), .load_i(idle_load), .stop_i(idle_stop), .expire_o(idle_exp)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      count_q       <= 3'd0;
      digits_q      <= 24'h0;
      vis_q         <= 1'b0;
      bcd_packet_q  <= '1;
      disp_enable_q <= 1'b0;
      pin_valid_q   <= 1'b0;
      pin_digits_q  <= 24'h0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      digits_q      <= digits_d;
      vis_q         <= vis_d;
      bcd_packet_q  <= bcdPac_t'(pkt_d);
      disp_enable_q <= 1'b1;
      pin_valid_q   <= sub_ok;
      pin_digits_q  <= pin_digits_d;
    end
  end
  assign bus.bcd_packet  = bcd_packet_q;
  assign bus.disp_enable = disp_enable_q;
  assign bus.digit_count = count_q;
  assign bus.pin_valid   = pin_valid_q;
  assign bus.pin_digits  = pin_digits_q;
endmodule

// File: tb/tb_pin_entry_display.sv
// tb_pin_entry_display: directed bench with MASK_CYCLES=4, IDLE_CYCLES=20
module tb_pin_entry_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  pin_entry_display_if bus();
  pin_entry_display #(.MASK_CYCLES(4), .IDLE_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic st(input string tag, input logic [23:0] pkt, input logic [2:0] cnt);
    chk({tag, "_pkt"}, bus.bcd_packet, pkt);
    chk({tag, "_cnt"}, {21'd0, bus.digit_count}, {21'd0, cnt});
  endtask
  task automatic outs(input string tag, input logic en, input logic pv, input logic [23:0] pd);
    chk({tag, "_en"}, {23'd0, bus.disp_enable}, {23'd0, en});
    chk({tag, "_pv"}, {23'd0, bus.pin_valid}, {23'd0, pv});
    chk({tag, "_pd"}, bus.pin_digits, pd);
  endtask
  task automatic key(input logic [3:0] c);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.reveal    = 1'b0;
    #1 rst = 1'b0;
    #1;
    st("rst", 24'hFFFFFF, 3'd0);
    outs("rst", 1'b0, 1'b0, 24'h0);
    @(negedge clk);
    chk("rst_hold_en", {23'd0, bus.disp_enable}, 24'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("release_en", {23'd0, bus.disp_enable}, 24'd1);
    st("release", 24'hFFFFFF, 3'd0);
    key(4'd1); key(4'd2); key(4'd3);
    st("k123", 24'hFFFAA3, 3'd3);
    idle(3);
    st("mask3", 24'hFFFAA3, 3'd3);
    idle(1);
    st("mask4", 24'hFFFAAA, 3'd3);
    bus.reveal = 1'b1;
    idle(1);
    st("reveal", 24'hFFF123, 3'd3);
    bus.reveal = 1'b0;
    idle(1);
    st("unreveal", 24'hFFFAAA, 3'd3);
    key(4'hC);
    st("clear", 24'hFFFFFF, 3'd0);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5); key(4'd6);
    st("six", 24'hAAAAA6, 3'd6);
    key(4'd7);
    st("seventh", 24'hAAAAA6, 3'd6);
    key(4'hD);
    st("ignored", 24'hAAAAA6, 3'd6);
    key(4'hE);
    outs("submit", 1'b1, 1'b1, 24'h123456);
    st("submit", 24'hFFFFFF, 3'd0);
    idle(1);
    outs("post_sub", 1'b1, 1'b0, 24'h123456);
    key(4'hB);
    st("bsp_empty", 24'hFFFFFF, 3'd0);
    key(4'd5); key(4'd9);
    st("k59", 24'hFFFFA9, 3'd2);
    key(4'hB);
    st("bsp", 24'hFFFFFA, 3'd1);
    key(4'hC);
    key(4'hE);
    chk("sub_short_pv", {23'd0, bus.pin_valid}, 24'd0);
    key(4'd4);
    st("k4", 24'hFFFFF4, 3'd1);
    idle(19);
    st("idle19", 24'hFFFFFA, 3'd1);
    idle(1);
    st("idle20", 24'hFFFFFF, 3'd0);
    key(4'd4);
    idle(19);
    key(4'd8);
    st("race", 24'hFFFFA8, 3'd2);
    idle(19);
    st("race19", 24'hFFFFAA, 3'd2);
    idle(1);
    st("race20", 24'hFFFFFF, 3'd0);
    key(4'd1); key(4'd2); key(4'd3);
    st("pre_arst", 24'hFFFAA3, 3'd3);
    #2 rst = 1'b0;
    #1;
    st("arst", 24'hFFFFFF, 3'd0);
    outs("arst", 1'b0, 1'b0, 24'h0);
    @(negedge clk);
    outs("arst_hold", 1'b0, 1'b0, 24'h0);
    rst = 1'b1;
    @(negedge clk);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5); key(4'd6);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'hE;
    #2 rst = 1'b0;
    #1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    outs("abort", 1'b0, 1'b0, 24'h0);
    st("abort", 24'hFFFFFF, 3'd0);
    rst = 1'b1;
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
